// File: rtl/unsigned_divider.sv
// rtl/unsigned_divider.sv - two-stage pipelined 4-bit unsigned restoring divider
module unsigned_divider (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [3:0] a_r;
    logic [3:0] b_r;
    logic       valid_r;
    logic [3:0] quotient;
    logic [4:0] rem;
    logic [4:0] trial;
    logic [3:0] dividend_bits;
    logic       unused_ok;

    assign uio_out   = 8'h00;
    assign uio_oe    = 8'h00;
    assign unused_ok = &{1'b0, ena, uio_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= 4'd0;
            b_r     <= 4'd0;
            valid_r <= 1'b0;
        end else begin
            a_r     <= ui_in[7:4];
            b_r     <= ui_in[3:0];
            valid_r <= 1'b1;
        end
    end

    // Restoring division, MSB first. The partial remainder stays below 2*B,
    // so it fits in five bits and bit 4 of the trial acts as its sign.
    always_comb begin
        rem           = 5'd0;
        trial         = 5'd0;
        quotient      = 4'd0;
        dividend_bits = a_r;
        for (int i = 0; i < 4; i++) begin
            rem           = {rem[3:0], dividend_bits[3]};
            dividend_bits = {dividend_bits[2:0], 1'b0};
            trial         = rem - {1'b0, b_r};
            if (!trial[4]) begin
                rem = trial;
            end
            quotient = {quotient[2:0], ~trial[4]};
        end
    end

    // valid_r keeps the output at zero after reset until a real operand pair
    // has been captured, instead of showing the 0/0 result of cleared registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uo_out <= 8'h00;
        end else if (valid_r) begin
            uo_out <= {quotient, rem[3:0]};
        end else begin
            uo_out <= 8'h00;
        end
    end

endmodule

// File: tb/tb_unsigned_divider.sv
// tb/tb_unsigned_divider.sv - self-checking bench for unsigned_divider
module tb_unsigned_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] ops_q[$];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] expected;
        string      name;
    } vec_t;

    vec_t table_v[$];

    always #5 clk = ~clk;

    unsigned_divider dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // Reference: plain integer division, with divide-by-zero giving Q=F, R=A.
    function automatic logic [7:0] model(input logic [7:0] op);
        int a;
        int b;
        a = int'(op[7:4]);
        b = int'(op[3:0]);
        if (b == 0) return {4'hF, op[7:4]};
        return {4'(a / b), 4'(a % b)};
    endfunction

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h", name, actual, expected);
        end
    endtask

    task automatic check_identity(input logic [7:0] op, input logic [7:0] res);
        int a, b, q, r;
        a = int'(op[7:4]);
        b = int'(op[3:0]);
        q = int'(res[7:4]);
        r = int'(res[3:0]);
        if (b != 0) begin
            vectors++;
            if (a != q * b + r || r >= b) begin
                errors++;
                $display("FAIL identity: op=%02h got Q=%0d R=%0d", op, q, r);
            end
        end
    endtask

    // Drives one operand per cycle; the result of the pair driven two
    // negedges earlier is compared before the next operand goes on.
    task automatic stream(input logic [7:0] op, input string name, input bit identity);
        logic [7:0] old;
        @(negedge clk);
        if (ops_q.size() == 2) begin
            old = ops_q.pop_front();
            check(name, uo_out, model(old));
            if (identity) check_identity(old, uo_out);
        end
        ena    = 1'($urandom);
        uio_in = 8'($urandom);
        ui_in  = op;
        ops_q.push_back(op);
    endtask

    task automatic flush(input string name, input bit identity);
        logic [7:0] old;
        while (ops_q.size() > 0) begin
            @(negedge clk);
            old = ops_q.pop_front();
            check(name, uo_out, model(old));
            if (identity) check_identity(old, uo_out);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        uio_in = 8'h00;
        ui_in  = 8'hFF;

        @(negedge clk);
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h00);

        // Release with 11/3 applied: output must stay zero for one more edge.
        rst_n = 1'b1;
        ui_in = {4'd11, 4'd3};
        @(negedge clk);
        check("post_reset_hold", uo_out, 8'h00);
        @(negedge clk);
        check("post_reset_first", uo_out, 8'h32);

        table_v.push_back('{4'd11, 4'd3,  8'h32, "div_11_3"});
        table_v.push_back('{4'd15, 4'd1,  8'hF0, "div_15_1"});
        table_v.push_back('{4'd5,  4'd10, 8'h05, "div_5_10"});
        table_v.push_back('{4'd9,  4'd0,  8'hF9, "div_9_0"});
        table_v.push_back('{4'd0,  4'd7,  8'h00, "div_0_7"});
        table_v.push_back('{4'd0,  4'd0,  8'hF0, "div_0_0"});
        table_v.push_back('{4'd15, 4'd15, 8'h10, "div_15_15"});
        table_v.push_back('{4'd14, 4'd4,  8'h32, "div_14_4"});
        table_v.push_back('{4'd15, 4'd2,  8'h71, "div_15_2"});
        table_v.push_back('{4'd7,  4'd1,  8'h70, "div_7_1"});

        for (int i = 0; i < table_v.size(); i++) begin
            ui_in  = {table_v[i].a, table_v[i].b};
            uio_in = 8'($urandom);
            @(negedge clk);
            @(negedge clk);
            check(table_v[i].name, uo_out, table_v[i].expected);
            check("uio_oe_const", uio_oe | uio_out, 8'h00);
        end

        for (int op = 0; op < 256; op++) begin
            stream(8'(op), "sweep", 1'b1);
        end
        flush("sweep", 1'b1);

        for (int i = 0; i < 200; i++) begin
            stream(8'($urandom), "random", 1'b0);
        end
        flush("random", 1'b0);

        // Asynchronous reset mid-stream, away from any clock edge.
        stream(8'h73, "pre_reset", 1'b0);
        stream(8'hE5, "pre_reset", 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", uo_out, 8'h00);
        ops_q.delete();
        @(negedge clk);
        check("reset_held", uo_out, 8'h00);
        rst_n = 1'b1;
        ui_in = {4'd13, 4'd4};
        @(negedge clk);
        check("mid_reset_hold", uo_out, 8'h00);
        ui_in = {4'd8, 4'd3};
        @(negedge clk);
        check("mid_reset_first", uo_out, 8'h31);
        @(negedge clk);
        check("mid_reset_second", uo_out, 8'h22);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
